// File: rtl/wb_master_arb_pkg.sv
// Shared types and bus widths for the two-master Wishbone arbiter.
package wb_master_arb_pkg;

  localparam int ADR_W = 20;
  localparam int DAT_W = 16;
  localparam int SEL_W = 2;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

endpackage

// File: rtl/wb_master_arb_if.sv
// Bundle of both master request ports and the shared switch-side bus.
// The arbiter takes the slave modport; the surrounding system takes master.
interface wb_master_arb_if;
  import wb_master_arb_pkg::*;

  logic [DAT_W-1:0] m0_dat_i;
  logic [ADR_W:1]   m0_adr_i;
  logic [SEL_W-1:0] m0_sel_i;
  logic             m0_we_i;
  logic             m0_cyc_i;
  logic             m0_stb_i;
  logic [DAT_W-1:0] m0_dat_o;
  logic             m0_ack_o;

  logic [DAT_W-1:0] m1_dat_i;
  logic [ADR_W:1]   m1_adr_i;
  logic [SEL_W-1:0] m1_sel_i;
  logic             m1_we_i;
  logic             m1_cyc_i;
  logic             m1_stb_i;
  logic [DAT_W-1:0] m1_dat_o;
  logic             m1_ack_o;

  logic [DAT_W-1:0] s_dat_o;
  logic [ADR_W:1]   s_adr_o;
  logic [SEL_W-1:0] s_sel_o;
  logic             s_we_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic [DAT_W-1:0] s_dat_i;
  logic             s_ack_i;

  logic             to_o;

  modport slave (
    input  m0_dat_i, m0_adr_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
    output m0_dat_o, m0_ack_o,
    input  m1_dat_i, m1_adr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
    output m1_dat_o, m1_ack_o,
    output s_dat_o, s_adr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i,
    output to_o
  );

  modport master (
    output m0_dat_i, m0_adr_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
    input  m0_dat_o, m0_ack_o,
    output m1_dat_i, m1_adr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
    input  m1_dat_o, m1_ack_o,
    input  s_dat_o, s_adr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i,
    input  to_o
  );

endinterface

// File: rtl/wb_arb_timer.sv
// Stall counter for the arbiter's forced-termination feature; only
// instantiated when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_timer
  import wb_master_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic gnt_chg_i,
  output logic to_o
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires on the TIMEOUT-th consecutive stalled strobe cycle.
  assign to_o = stb_i & ~ack_i & (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (to_o || !stb_i || ack_i || gnt_chg_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_master_arb.sv
// Two-master round-robin Wishbone arbiter with atomic bursts.
// Define WB_ARB_TIMEOUT_EN to build the stalled-slave forced termination.
module wb_master_arb
  import wb_master_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  wb_master_arb_if.slave bus
);

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   gnt0, gnt1;
  logic   s_stb_w;
  logic   ack_any;
  logic   to_w;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Grant only moves when the owner releases cyc, so bursts stay atomic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
          state_d = last_gnt_q ? GNT0 : GNT1;
        end else if (bus.m0_cyc_i) begin
          state_d = GNT0;
        end else if (bus.m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!bus.m0_cyc_i) begin
          state_d = bus.m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!bus.m1_cyc_i) begin
          state_d = bus.m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    last_gnt_d = last_gnt_q;
    if (state_d == GNT0) begin
      last_gnt_d = 1'b0;
    end else if (state_d == GNT1) begin
      last_gnt_d = 1'b1;
    end
  end

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  // Address/data/select follow master 0 unless master 1 owns the bus.
  assign bus.s_adr_o = gnt1 ? bus.m1_adr_i : bus.m0_adr_i;
  assign bus.s_sel_o = gnt1 ? bus.m1_sel_i : bus.m0_sel_i;
  assign bus.s_dat_o = gnt1 ? bus.m1_dat_i : bus.m0_dat_i;
  assign bus.s_we_o  = gnt1 ? bus.m1_we_i  : bus.m0_we_i;

  assign bus.s_cyc_o = ~wb_rst_i & ((gnt0 & bus.m0_cyc_i) | (gnt1 & bus.m1_cyc_i));
  assign s_stb_w     = ~wb_rst_i & ((gnt0 & bus.m0_cyc_i & bus.m0_stb_i) |
                                    (gnt1 & bus.m1_cyc_i & bus.m1_stb_i));
  assign bus.s_stb_o = s_stb_w;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .stb_i     (s_stb_w),
    .ack_i     (bus.s_ack_i),
    .gnt_chg_i (state_d != state_q),
    .to_o      (to_w)
  );
`else
  assign to_w = 1'b0;
`endif

  assign ack_any = bus.s_ack_i | to_w;

  assign bus.m0_ack_o = ~wb_rst_i & gnt0 & bus.m0_stb_i & ack_any;
  assign bus.m1_ack_o = ~wb_rst_i & gnt1 & bus.m1_stb_i & ack_any;

  // A forced termination returns all-ones so software can spot the abort.
  assign bus.m0_dat_o = to_w ? {DAT_W{1'b1}} : bus.s_dat_i;
  assign bus.m1_dat_o = to_w ? {DAT_W{1'b1}} : bus.s_dat_i;

  assign bus.to_o = to_w;

endmodule
